// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Requester, ALU-datapath and response signals of alu_arbiter.
//            slave = arbiter side, master = surrounding logic.
// Revision : 1.0  initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic [WIDTH-1:0] alu_r2;
    logic [WIDTH-1:0] alu_r3;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_r0;
    logic             alu_overflow;
    logic             alu_zero;
    logic             alu_carry;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic [2:0]       rsp_flags;

    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_r2, alu_r3, alu_op,
        input  alu_r0, alu_overflow, alu_zero, alu_carry,
        output rsp_valid, rsp_id, rsp_data, rsp_flags,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_r2, alu_r3, alu_op,
        output alu_r0, alu_overflow, alu_zero, alu_carry,
        input  rsp_valid, rsp_id, rsp_data, rsp_flags,
        output rsp_ready,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one registered ALU datapath between two requesters and
//            returns R0 plus {overflow, zero, carry} over a valid/ready channel.
//            Macro ALU_ARB_FIXED_PRIO_EN: fixed priority (requester 0 wins)
//            instead of round-robin.
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    alu_arbiter_if.slave bus
);

    localparam logic [3:0] c_lat_load = 4'(ALU_LAT - 1);

    if (ALU_LAT < 1 || ALU_LAT > 15) begin : g_lat_range_check
        $error("alu_arbiter: ALU_LAT must be within 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_lat_cnt;

    logic             w_any_valid;
    logic             w_winner;
    logic             w_grant;
    logic             w_capture;
    logic             w_rsp_done;

    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_owner;

    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic [2:0]       r_rsp_flags;

    assign w_any_valid = bus.req0_valid | bus.req1_valid;

    // w_winner: 0 selects requester 0, 1 selects requester 1
`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        w_winner = ~bus.req0_valid;
    end
`else
    logic r_rr_last;

    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            w_winner = ~r_rr_last;
        end else begin
            w_winner = bus.req1_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (w_grant) begin
            r_rr_last <= w_winner;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Ready is combinational, so keep it quiet while reset is held
                if (w_any_valid && !rst) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_lat_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_owner     <= 1'b0;
            r_lat_cnt   <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
        end else begin
            if (w_grant) begin
                r_alu_a  <= w_winner ? bus.req1_a  : bus.req0_a;
                r_alu_b  <= w_winner ? bus.req1_b  : bus.req0_b;
                r_alu_op <= w_winner ? bus.req1_op : bus.req0_op;
                r_owner  <= w_winner;
            end

            // ISSUE spends one of the ALU_LAT cycles, hence the minus one
            if (r_state == S_ISSUE) begin
                r_lat_cnt <= c_lat_load;
            end else if (r_state == S_WAIT && r_lat_cnt != 4'd0) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end

            if (w_capture) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_owner;
                r_rsp_data  <= bus.alu_r0;
                r_rsp_flags <= {bus.alu_overflow, bus.alu_zero, bus.alu_carry};
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = w_grant & ~w_winner;
    assign bus.req1_ready = w_grant &  w_winner;
    assign bus.alu_r2     = r_alu_a;
    assign bus.alu_r3     = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Bench for alu_arbiter, one unit at ALU_LAT=1 and one at ALU_LAT=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int W = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam logic [3:0] c_order = 4'b0000;
`else
    localparam logic [3:0] c_order = 4'b0101;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         rq_valid [2][2];
    logic [W-1:0] rq_a     [2][2];
    logic [W-1:0] rq_b     [2][2];
    logic [2:0]   rq_op    [2][2];
    logic         rs_ready [2];

    logic         o_ready  [2][2];
    logic [W-1:0] o_r2     [2];
    logic [W-1:0] o_r3     [2];
    logic [2:0]   o_op     [2];
    logic         o_rv     [2];
    logic         o_id     [2];
    logic [W-1:0] o_data   [2];
    logic [2:0]   o_flags  [2];
    logic         o_busy   [2];

    function automatic logic [W+2:0] stub_alu(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {(a[W-1] == b[W-1]) && (s[W-1] != a[W-1]), s[W-1:0] == '0, s[W], s[W-1:0]};
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_unit
        localparam int LATK = (k == 0) ? 1 : 4;
        alu_arbiter_if #(.WIDTH(W)) bus ();
        logic [W+2:0] pipe [LATK];

        assign bus.req0_valid = rq_valid[k][0];
        assign bus.req0_a     = rq_a[k][0];
        assign bus.req0_b     = rq_b[k][0];
        assign bus.req0_op    = rq_op[k][0];
        assign bus.req1_valid = rq_valid[k][1];
        assign bus.req1_a     = rq_a[k][1];
        assign bus.req1_b     = rq_b[k][1];
        assign bus.req1_op    = rq_op[k][1];
        assign bus.rsp_ready  = rs_ready[k];

        assign o_ready[k][0] = bus.req0_ready;
        assign o_ready[k][1] = bus.req1_ready;
        assign o_r2[k]       = bus.alu_r2;
        assign o_r3[k]       = bus.alu_r3;
        assign o_op[k]       = bus.alu_op;
        assign o_rv[k]       = bus.rsp_valid;
        assign o_id[k]       = bus.rsp_id;
        assign o_data[k]     = bus.rsp_data;
        assign o_flags[k]    = bus.rsp_flags;
        assign o_busy[k]     = bus.busy;

        // Stub datapath: registered adder, ALU_LAT clocks deep
        always @(posedge clk) begin
            pipe[0] <= stub_alu(bus.alu_r2, bus.alu_r3);
            for (int i = 1; i < LATK; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.alu_r0       = pipe[LATK-1][W-1:0];
        assign bus.alu_carry    = pipe[LATK-1][W];
        assign bus.alu_zero     = pipe[LATK-1][W+1];
        assign bus.alu_overflow = pipe[LATK-1][W+2];

        alu_arbiter #(.WIDTH(W), .ALU_LAT(LATK)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    int n_chk;
    int n_fail;
    int cyc;

    // Transaction-level reference: phase counter since accept, payload, result
    bit           m_busy  [2];
    int           m_p     [2];
    bit           m_rr    [2];
    logic         m_owner [2];
    logic [W-1:0] m_a     [2];
    logic [W-1:0] m_b     [2];
    logic [2:0]   m_op    [2];
    logic [W+2:0] m_res   [2];
    logic [W-1:0] m_data  [2];
    logic [2:0]   m_flags [2];
    logic         m_id    [2];

    int           acc_cyc [2];
    int           rv_cyc  [2];
    bit           prev_rv [2];
    int           rdy_cnt [2][2];
    bit           acc     [2][2];
    logic [7:0]   id_hist [2];
    int           rsp_cnt [2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic [W+2:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
        longint su;
        longint ss;
        su = longint'(a) + longint'(b);
        ss = longint'($signed(a)) + longint'($signed(b));
        return {ss != longint'($signed(su[31:0])), su[31:0] == 32'd0, su[32], su[31:0]};
    endfunction

    function automatic int pick(input int k);
        bit v0;
        bit v1;
        v0 = (rq_valid[k][0] === 1'b1);
        v1 = (rq_valid[k][1] === 1'b1);
        if (!v0 && !v1) return -1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return v0 ? 0 : 1;
`else
        if (v0 && v1) return m_rr[k] ? 0 : 1;
        return v0 ? 0 : 1;
`endif
    endfunction

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input int k, input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL u%0d %s: got %h expected %h (cycle %0d)", k, nm, act, exp, cyc);
        end
    endtask

    task automatic check_cycle();
        int  w;
        bit  e_rv;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k]  = 1'b0;
                m_p[k]     = 0;
                m_rr[k]    = 1'b1;
                m_owner[k] = 1'b0;
                m_a[k]     = '0;
                m_b[k]     = '0;
                m_op[k]    = '0;
                m_data[k]  = '0;
                m_flags[k] = '0;
                m_id[k]    = 1'b0;
            end
            w    = (rst || m_busy[k]) ? -1 : pick(k);
            e_rv = m_busy[k] && (m_p[k] >= lat_of(k) + 2);

            chk(k, "req0_ready", W'(o_ready[k][0]), W'(w == 0));
            chk(k, "req1_ready", W'(o_ready[k][1]), W'(w == 1));
            chk(k, "busy",       W'(o_busy[k]),     W'(m_busy[k]));
            chk(k, "rsp_valid",  W'(o_rv[k]),       W'(e_rv));
            chk(k, "rsp_id",     W'(o_id[k]),       W'(m_id[k]));
            chk(k, "rsp_data",   o_data[k],         m_data[k]);
            chk(k, "rsp_flags",  W'(o_flags[k]),    W'(m_flags[k]));
            chk(k, "alu_r2",     o_r2[k],           m_a[k]);
            chk(k, "alu_r3",     o_r3[k],           m_b[k]);
            chk(k, "alu_op",     W'(o_op[k]),       W'(m_op[k]));

            for (int r = 0; r < 2; r++) begin
                acc[k][r] = (o_ready[k][r] === 1'b1);
                if (acc[k][r]) begin
                    rdy_cnt[k][r]++;
                    acc_cyc[k] = cyc;
                end
            end
            if (o_rv[k] === 1'b1 && !prev_rv[k]) rv_cyc[k] = cyc;
            prev_rv[k] = (o_rv[k] === 1'b1);
            if (o_rv[k] === 1'b1 && rs_ready[k]) begin
                if (rsp_cnt[k] < 4) id_hist[k] = {id_hist[k][6:0], o_id[k]};
                rsp_cnt[k]++;
            end

            if (!rst) begin
                if (w >= 0) begin
                    m_busy[k]  = 1'b1;
                    m_p[k]     = 1;
                    m_owner[k] = w[0];
                    m_rr[k]    = w[0];
                    m_a[k]     = rq_a[k][w];
                    m_b[k]     = rq_b[k][w];
                    m_op[k]    = rq_op[k][w];
                    m_res[k]   = ref_add(m_a[k], m_b[k]);
                end else if (m_busy[k]) begin
                    if (e_rv) begin
                        if (rs_ready[k]) m_busy[k] = 1'b0;
                    end else begin
                        m_p[k]++;
                        if (m_p[k] == lat_of(k) + 2) begin
                            m_data[k]  = m_res[k][W-1:0];
                            m_flags[k] = m_res[k][W+2:W];
                            m_id[k]    = m_owner[k];
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int r);
        rq_valid[k][r] = 1'b1;
        rq_a[k][r]     = rand_word();
        rq_b[k][r]     = rand_word();
        rq_op[k][r]    = 3'($urandom_range(0, 7));
    endtask

    // Issue one operation on both units and wait until both hold a response
    task automatic wait_rsp(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        int n;
        for (int k = 0; k < 2; k++) begin
            rq_valid[k][r] = 1'b1;
            rq_a[k][r]     = a;
            rq_b[k][r]     = b;
            rq_op[k][r]    = op;
            rs_ready[k]    = 1'b0;
            rdy_cnt[k][r]  = 0;
        end
        n = 0;
        while (!(o_rv[0] === 1'b1 && o_rv[1] === 1'b1) && n < 40) begin
            tick();
            n++;
            for (int k = 0; k < 2; k++) if (acc[k][r]) rq_valid[k][r] = 1'b0;
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            rq_valid[k][r] = 1'b0;
            chk(k, "rsp_valid within bound", W'(o_rv[k]), 32'd1);
            chk(k, "accept-to-rsp latency", W'(rv_cyc[k] - acc_cyc[k]), W'(lat_of(k) + 2));
            chk(k, "ready pulse count", W'(rdy_cnt[k][r]), 32'd1);
        end
    endtask

    task automatic release_rsp();
        rs_ready[0] = 1'b1;
        rs_ready[1] = 1'b1;
        tick();
        rs_ready[0] = 1'b0;
        rs_ready[1] = 1'b0;
    endtask

    initial begin
        int n;
        int rv_cnt [2];
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                rq_valid[k][r] = 1'b0;
                rq_a[k][r]     = '0;
                rq_b[k][r]     = '0;
                rq_op[k][r]    = '0;
                rdy_cnt[k][r]  = 0;
                acc[k][r]      = 1'b0;
            end
            rs_ready[k] = 1'b0;
            prev_rv[k]  = 1'b0;
            acc_cyc[k]  = 0;
            rv_cyc[k]   = 0;
            id_hist[k]  = '0;
            rsp_cnt[k]  = 0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk(k, "reset busy",      W'(o_busy[k]),  32'd0);
            chk(k, "reset rsp_valid", W'(o_rv[k]),    32'd0);
            chk(k, "reset rsp_data",  o_data[k],      32'd0);
            chk(k, "reset alu_r2",    o_r2[k],        32'd0);
        end
        rst = 1'b0;
        tick();

        // Contention: both requesters valid for four operations, consumer ready
        for (int k = 0; k < 2; k++) begin
            rs_ready[k] = 1'b1;
            set_req(k, 0);
            set_req(k, 1);
        end
        n = 0;
        while ((rsp_cnt[0] < 4 || rsp_cnt[1] < 4) && n < 200) begin
            tick();
            n++;
            for (int k = 0; k < 2; k++) begin
                if (rsp_cnt[k] >= 4) begin
                    rq_valid[k][0] = 1'b0;
                    rq_valid[k][1] = 1'b0;
                end else begin
                    for (int r = 0; r < 2; r++) if (acc[k][r]) set_req(k, r);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk(k, "contention responses", W'(rsp_cnt[k] >= 4), 32'd1);
            chk(k, "contention id order", W'(id_hist[k][3:0]), W'(c_order));
            rs_ready[k] = 1'b0;
        end
        tick();
        tick();

        // Single request
        wait_rsp(0, 32'h0000_0005, 32'h0000_0003, 3'b010);
        for (int k = 0; k < 2; k++) begin
            chk(k, "single alu_op",    W'(o_op[k]),    32'd2);
            chk(k, "single rsp_data",  o_data[k],      32'h0000_0008);
            chk(k, "single rsp_flags", W'(o_flags[k]), 32'd0);
            chk(k, "single rsp_id",    W'(o_id[k]),    32'd0);
        end
        release_rsp();

        // Carry and zero from requester 1
        wait_rsp(1, 32'hFFFF_FFFF, 32'h0000_0001, 3'b000);
        for (int k = 0; k < 2; k++) begin
            chk(k, "carry rsp_data",  o_data[k],      32'h0000_0000);
            chk(k, "carry rsp_flags", W'(o_flags[k]), 32'd3);
            chk(k, "carry rsp_id",    W'(o_id[k]),    32'd1);
        end
        release_rsp();

        // Signed overflow
        wait_rsp(0, 32'h7FFF_FFFF, 32'h0000_0001, 3'b001);
        for (int k = 0; k < 2; k++) begin
            chk(k, "ovf rsp_data",  o_data[k],      32'h8000_0000);
            chk(k, "ovf rsp_flags", W'(o_flags[k]), 32'd4);
        end
        release_rsp();

        // Back-pressure with a competing request pending
        wait_rsp(0, 32'h0000_0010, 32'h0000_0020, 3'b011);
        for (int k = 0; k < 2; k++) begin
            rq_valid[k][1] = 1'b1;
            rq_a[k][1]     = 32'h1234_5678;
            rq_b[k][1]     = 32'h1111_1111;
            rdy_cnt[k][1]  = 0;
        end
        repeat (10) begin
            tick();
            for (int k = 0; k < 2; k++) chk(k, "busy while held", W'(o_busy[k]), 32'd1);
        end
        for (int k = 0; k < 2; k++) begin
            chk(k, "no ready while held", W'(rdy_cnt[k][1]), 32'd0);
            chk(k, "held rsp_data", o_data[k], 32'h0000_0030);
        end
        release_rsp();
        for (int k = 0; k < 2; k++) begin
            chk(k, "idle after release", W'(o_busy[k]), 32'd0);
            rq_valid[k][1] = 1'b0;
        end
        tick();

        // Reset while waiting on the datapath
        for (int k = 0; k < 2; k++) begin
            rq_valid[k][0] = 1'b1;
            rq_a[k][0]     = 32'd5;
            rq_b[k][0]     = 32'd7;
            rq_op[k][0]    = 3'b000;
            acc[k][0]      = 1'b0;
        end
        n = 0;
        while (!(rq_valid[0][0] === 1'b0 && rq_valid[1][0] === 1'b0) && n < 20) begin
            tick();
            n++;
            for (int k = 0; k < 2; k++) if (acc[k][0]) rq_valid[k][0] = 1'b0;
        end
        tick();
        rst = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst busy",      W'(o_busy[k]),  32'd0);
            chk(k, "rst rsp_valid", W'(o_rv[k]),    32'd0);
            chk(k, "rst rsp_data",  o_data[k],      32'd0);
            chk(k, "rst alu_r2",    o_r2[k],        32'd0);
            chk(k, "rst alu_r3",    o_r3[k],        32'd0);
            rv_cnt[k] = 0;
        end
        rst = 1'b0;
        repeat (12) begin
            tick();
            for (int k = 0; k < 2; k++) if (o_rv[k] === 1'b1) rv_cnt[k]++;
        end
        for (int k = 0; k < 2; k++) chk(k, "no rsp after reset", W'(rv_cnt[k]), 32'd0);

        // Randomised traffic with back-pressure and abandoned requests
        for (int t = 0; t < 1500; t++) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 2; r++) begin
                    if (acc[k][r] || rq_valid[k][r] !== 1'b1) begin
                        if ($urandom_range(0, 1) == 1) set_req(k, r);
                        else rq_valid[k][r] = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        rq_valid[k][r] = 1'b0;
                    end
                end
                rs_ready[k] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
